// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-side signals of the two-port memory arbiter.
// Slave modport is the arbiter; master modport is the requesters plus memory.
// Port 0 is instruction fetch, port 1 is load/store.
interface mem_port_arbiter_if #(parameter int N = 32);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [31:0]   adr0;
    logic [31:0]   adr1;
    logic [N-1:0]  wdata0;
    logic [N-1:0]  wdata1;
    logic          ack0;
    logic          ack1;
    logic [N-1:0]  rdata0;
    logic [N-1:0]  rdata1;
    logic          busy;
    logic [31:0]   memAdr;
    logic [N-1:0]  writeData;
    logic          memWrite;
    logic [N-1:0]  readData;

    modport slave (
        input  req0, req1, we0, we1, adr0, adr1, wdata0, wdata1, readData,
        output ack0, ack1, rdata0, rdata1, busy, memAdr, writeData, memWrite
    );

    modport master (
        output req0, req1, we0, we1, adr0, adr1, wdata0, wdata1, readData,
        input  ack0, ack1, rdata0, rdata1, busy, memAdr, writeData, memWrite
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data memory between fetch (port 0) and load/store (port 1).
// Latency: request sampled at edge k, memory access in cycle k+1, ack pulse in cycle k+2.
// Backpressure: requesters hold req until ack; losing port simply waits, one access per 3 cycles.
module mem_port_arbiter #(
    parameter int N = 32
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SERVE, DONE} state_t;

    state_t        state_q;
    logic          sel_q;       // index of the port being served
    logic          last_q;      // port granted most recently
    logic          we_q;
    logic [31:0]   adr_q;
    logic [N-1:0]  wdata_q;
    logic [N-1:0]  rdata0_q;
    logic [N-1:0]  rdata1_q;
    logic          ack0_q;
    logic          ack1_q;
    logic          busy_q;
    logic          win_d;

    // Winner: a lone requester wins; on a tie the port not granted last time wins.
    always_comb begin
        win_d = bus.req1;
        if (bus.req0 && bus.req1) begin
            win_d = ~last_q;
        end
    end

    // Control FSM with latched request and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            adr_q    <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        sel_q   <= win_d;
                        last_q  <= win_d;
                        we_q    <= win_d ? bus.we1    : bus.we0;
                        adr_q   <= win_d ? bus.adr1   : bus.adr0;
                        wdata_q <= win_d ? bus.wdata1 : bus.wdata0;
                        busy_q  <= 1'b1;
                        state_q <= SERVE;
                    end
                end
                SERVE: begin
                    // Reads capture the memory word as SERVE ends; writes leave rdata alone.
                    if (!we_q) begin
                        if (sel_q) begin
                            rdata1_q <= bus.readData;
                        end else begin
                            rdata0_q <= bus.readData;
                        end
                    end
                    ack0_q  <= ~sel_q;
                    ack1_q  <= sel_q;
                    state_q <= DONE;
                end
                DONE: begin
                    // Requests are ignored here so a held req is re-sampled only in IDLE.
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Write enable is combinational so an asynchronous reset kills it immediately.
    assign bus.memWrite  = (state_q == SERVE) && we_q;
    assign bus.memAdr    = adr_q;
    assign bus.writeData = wdata_q;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.busy      = busy_q;

endmodule
